// File: rtl/game_pkg.sv
// Shared encodings for the OLED game: FSM states, display-source selects,
// winner codes, and small scoring helpers.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_HOLD      = 2'd2,
    ST_MATCH_END = 2'd3
  } state_e;

  localparam logic [1:0] DISP_TITLE      = 2'd0;
  localparam logic [1:0] DISP_GAME       = 2'd1;
  localparam logic [1:0] DISP_ROUND_OVER = 2'd2;
  localparam logic [1:0] DISP_MATCH_OVER = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  function automatic logic [1:0] disp_of(input state_e s);
    logic [1:0] d;
    unique case (s)
      ST_PLAY:      d = DISP_GAME;
      ST_HOLD:      d = DISP_ROUND_OVER;
      ST_MATCH_END: d = DISP_MATCH_OVER;
      default:      d = DISP_TITLE;
    endcase
    return d;
  endfunction

  // Higher value wins; equal values are a draw.
  function automatic logic [1:0] winner_of(input logic [1:0] a, input logic [1:0] b);
    if (a > b) return WIN_P1;
    if (b > a) return WIN_P2;
    return WIN_NONE;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Player inputs and match-status outputs of the round sequencer, bundled as one port.
interface round_sequencer_if;

  logic       start_btn;
  logic       p1_done;
  logic       p2_done;
  logic [1:0] green_block_count_p1;
  logic [1:0] green_block_count_p2;

  logic [1:0] disp_sel;
  logic       round_active;
  logic [1:0] round_num;
  logic [5:0] time_left;
  logic [1:0] score_p1;
  logic [1:0] score_p2;
  logic [1:0] latched_green_p1;
  logic [1:0] latched_green_p2;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  modport master (
    output start_btn, p1_done, p2_done, green_block_count_p1, green_block_count_p2,
    input  disp_sel, round_active, round_num, time_left, score_p1, score_p2,
           latched_green_p1, latched_green_p2, round_winner, match_winner
  );

  modport slave (
    input  start_btn, p1_done, p2_done, green_block_count_p1, green_block_count_p2,
    output disp_sel, round_active, round_num, time_left, score_p1, score_p2,
           latched_green_p1, latched_green_p2, round_winner, match_winner
  );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second timebase: pulses tick every CLK_FREQ_HZ enabled cycles; clear
// restarts the count so the first tick lands a full second after it.
module sec_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic basys3_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge basys3_clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Decoded from the register only, so the FSM may use it to compute clear without a loop.
  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: match-level FSM for the two-player OLED game. Runs the
// round countdown, scores each round and selects the OLED renderer.
module round_sequencer
  import game_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int ROUND_TIME_S  = 30,
  parameter int OVER_HOLD_S   = 3,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 3
) (
  input  logic             basys3_clk,
  input  logic             reset,
  round_sequencer_if.slave bus
);

  localparam int              HW         = (OVER_HOLD_S > 1) ? $clog2(OVER_HOLD_S) : 1;
  localparam logic [HW-1:0]   HOLD_LAST  = HW'(OVER_HOLD_S - 1);
  localparam logic [5:0]      TIME_INIT  = 6'(ROUND_TIME_S);
  localparam logic [1:0]      WIN_SCORE  = 2'(ROUNDS_TO_WIN);
  localparam logic [1:0]      LAST_ROUND = 2'(MAX_ROUNDS);

  state_e        state_q, state_d;
  logic [1:0]    disp_sel_q, disp_sel_d;
  logic          round_active_q, round_active_d;
  logic [1:0]    round_num_q, round_num_d;
  logic [5:0]    time_left_q, time_left_d;
  logic [1:0]    score_p1_q, score_p1_d;
  logic [1:0]    score_p2_q, score_p2_d;
  logic [1:0]    latched_p1_q, latched_p1_d;
  logic [1:0]    latched_p2_q, latched_p2_d;
  logic [1:0]    round_winner_q, round_winner_d;
  logic [1:0]    match_winner_q, match_winner_d;
  logic          d1_q, d1_d;
  logic          d2_q, d2_d;
  logic [HW-1:0] hold_sec_q, hold_sec_d;

  logic tick, tick_clear, tick_en;
  logic [1:0] rw;

  assign tick_en = (state_q == ST_PLAY) || (state_q == ST_HOLD);

  sec_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .basys3_clk (basys3_clk),
    .reset      (reset),
    .clear      (tick_clear),
    .enable     (tick_en),
    .tick       (tick)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d        = state_q;
    round_num_d    = round_num_q;
    time_left_d    = time_left_q;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    latched_p1_d   = latched_p1_q;
    latched_p2_d   = latched_p2_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    d1_d           = d1_q;
    d2_d           = d2_q;
    hold_sec_d     = hold_sec_q;
    rw             = WIN_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_btn) begin
          state_d        = ST_PLAY;
          round_num_d    = 2'd1;
          time_left_d    = TIME_INIT;
          score_p1_d     = '0;
          score_p2_d     = '0;
          latched_p1_d   = '0;
          latched_p2_d   = '0;
          round_winner_d = WIN_NONE;
          match_winner_d = WIN_NONE;
          d1_d           = 1'b0;
          d2_d           = 1'b0;
        end
      end
      ST_PLAY: begin
        d1_d = d1_q | bus.p1_done;
        d2_d = d2_q | bus.p2_done;
        if (tick && (time_left_q != '0)) time_left_d = time_left_q - 1'b1;
        // A done pulse on the completing cycle counts, hence the _d flags.
        if ((d1_d && d2_d) || (time_left_q == '0)) begin
          state_d        = ST_HOLD;
          hold_sec_d     = '0;
          latched_p1_d   = bus.green_block_count_p1;
          latched_p2_d   = bus.green_block_count_p2;
          rw             = winner_of(bus.green_block_count_p1, bus.green_block_count_p2);
          round_winner_d = rw;
          if (rw == WIN_P1) score_p1_d = sat_inc(score_p1_q);
          if (rw == WIN_P2) score_p2_d = sat_inc(score_p2_q);
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (hold_sec_q == HOLD_LAST) begin
            if ((score_p1_q == WIN_SCORE) || (score_p2_q == WIN_SCORE) ||
                (round_num_q == LAST_ROUND)) begin
              state_d        = ST_MATCH_END;
              match_winner_d = winner_of(score_p1_q, score_p2_q);
            end else begin
              state_d     = ST_PLAY;
              round_num_d = round_num_q + 2'd1;
              time_left_d = TIME_INIT;
              d1_d        = 1'b0;
              d2_d        = 1'b0;
            end
          end else begin
            hold_sec_d = hold_sec_q + 1'b1;
          end
        end
      end
      ST_MATCH_END: begin
        if (bus.start_btn) begin
          state_d        = ST_IDLE;
          round_num_d    = '0;
          time_left_d    = '0;
          score_p1_d     = '0;
          score_p2_d     = '0;
          latched_p1_d   = '0;
          latched_p2_d   = '0;
          round_winner_d = WIN_NONE;
          match_winner_d = WIN_NONE;
          d1_d           = 1'b0;
          d2_d           = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tick_clear     = (state_d != state_q);
    disp_sel_d     = disp_of(state_d);
    round_active_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge basys3_clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      disp_sel_q     <= '0;
      round_active_q <= 1'b0;
      round_num_q    <= '0;
      time_left_q    <= '0;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      latched_p1_q   <= '0;
      latched_p2_q   <= '0;
      round_winner_q <= '0;
      match_winner_q <= '0;
      d1_q           <= 1'b0;
      d2_q           <= 1'b0;
      hold_sec_q     <= '0;
    end else begin
      state_q        <= state_d;
      disp_sel_q     <= disp_sel_d;
      round_active_q <= round_active_d;
      round_num_q    <= round_num_d;
      time_left_q    <= time_left_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      latched_p1_q   <= latched_p1_d;
      latched_p2_q   <= latched_p2_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
      d1_q           <= d1_d;
      d2_q           <= d2_d;
      hold_sec_q     <= hold_sec_d;
    end
  end

  assign bus.disp_sel         = disp_sel_q;
  assign bus.round_active     = round_active_q;
  assign bus.round_num        = round_num_q;
  assign bus.time_left        = time_left_q;
  assign bus.score_p1         = score_p1_q;
  assign bus.score_p2         = score_p2_q;
  assign bus.latched_green_p1 = latched_p1_q;
  assign bus.latched_green_p2 = latched_p2_q;
  assign bus.round_winner     = round_winner_q;
  assign bus.match_winner     = match_winner_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed match scenarios plus random
// matches, checked against a round-level model of the game rules.
module tb_round_sequencer;
  import game_pkg::*;

  localparam int F     = 10;
  localparam int RT    = 3;
  localparam int HS    = 2;
  localparam int NEVER = 1000;

  logic basys3_clk = 1'b0;
  logic reset      = 1'b1;

  round_sequencer_if bus ();

  round_sequencer #(
    .CLK_FREQ_HZ   (F),
    .ROUND_TIME_S  (RT),
    .OVER_HOLD_S   (HS),
    .ROUNDS_TO_WIN (2),
    .MAX_ROUNDS    (3)
  ) dut (
    .basys3_clk (basys3_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 basys3_clk = ~basys3_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Round-level model of the match
  int m_round, m_s1, m_s2, m_rw;
  bit m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge basys3_clk);
    #1;
  endtask

  function automatic int win_code(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_disp"},   bus.disp_sel,         0);
    check({tag, "_active"}, bus.round_active,     0);
    check({tag, "_round"},  bus.round_num,        0);
    check({tag, "_time"},   bus.time_left,        0);
    check({tag, "_s1"},     bus.score_p1,         0);
    check({tag, "_s2"},     bus.score_p2,         0);
    check({tag, "_l1"},     bus.latched_green_p1, 0);
    check({tag, "_l2"},     bus.latched_green_p2, 0);
    check({tag, "_rw"},     bus.round_winner,     0);
    check({tag, "_mw"},     bus.match_winner,     0);
  endtask

  task automatic start_match();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    m_round = 1; m_s1 = 0; m_s2 = 0; m_rw = 0; m_over = 1'b0;
    check("start_disp",   bus.disp_sel,     DISP_GAME);
    check("start_round",  bus.round_num,    1);
    check("start_time",   bus.time_left,    RT);
    check("start_active", bus.round_active, 1);
    check("start_s1",     bus.score_p1,     0);
    check("start_rw",     bus.round_winner, 0);
  endtask

  // Plays one round from PLAY entry. c1/c2: cycle of each done pulse (NEVER = none).
  // Counts are fixed (g1f/g2f) or, when rnd is set, re-randomised every cycle.
  task automatic play_round(input int c1, input int c2, input bit rnd,
                            input int g1f, input int g2f);
    int last, end_c, g1, g2, tl;
    last  = (c1 > c2) ? c1 : c2;
    end_c = (last < RT * F) ? last : RT * F;
    g1 = g1f; g2 = g2f;
    for (int c = 0; c <= end_c; c++) begin
      bus.p1_done = (c == c1);
      bus.p2_done = (c == c2);
      if (rnd) begin
        g1 = $urandom_range(0, 3);
        g2 = $urandom_range(0, 3);
      end
      bus.green_block_count_p1 = 2'(g1);
      bus.green_block_count_p2 = 2'(g2);
      step();
      if (c < end_c) begin
        tl = RT - (c + 1) / F;
        if (tl < 0) tl = 0;
        check("play_disp", bus.disp_sel,  DISP_GAME);
        check("play_time", bus.time_left, tl);
      end
    end
    bus.p1_done = 1'b0;
    bus.p2_done = 1'b0;
    m_rw = win_code(g1, g2);
    if (m_rw == 1 && m_s1 < 3) m_s1++;
    if (m_rw == 2 && m_s2 < 3) m_s2++;
    check("end_disp",   bus.disp_sel,         DISP_ROUND_OVER);
    check("end_active", bus.round_active,     0);
    check("end_rw",     bus.round_winner,     m_rw);
    check("end_s1",     bus.score_p1,         m_s1);
    check("end_s2",     bus.score_p2,         m_s2);
    check("end_l1",     bus.latched_green_p1, g1);
    check("end_l2",     bus.latched_green_p2, g2);
    check("end_round",  bus.round_num,        m_round);
  endtask

  // Runs the banner from HOLD entry; start and done pulses in HOLD must be ignored.
  task automatic hold_phase(input bit poke);
    for (int k = 1; k < HS * F; k++) begin
      bus.start_btn = poke && (k == 5);
      bus.p1_done   = (k == 7);
      step();
      check("hold_disp", bus.disp_sel, DISP_ROUND_OVER);
    end
    bus.start_btn = 1'b0;
    bus.p1_done   = 1'b0;
    step();
    if (m_s1 == 2 || m_s2 == 2 || m_round == 3) begin
      m_over = 1'b1;
      check("me_disp", bus.disp_sel,     DISP_MATCH_OVER);
      check("me_mw",   bus.match_winner, win_code(m_s1, m_s2));
      check("me_s1",   bus.score_p1,     m_s1);
      check("me_s2",   bus.score_p2,     m_s2);
    end else begin
      m_round++;
      check("next_disp",  bus.disp_sel,     DISP_GAME);
      check("next_round", bus.round_num,    m_round);
      check("next_time",  bus.time_left,    RT);
      check("next_rw",    bus.round_winner, m_rw);
    end
  endtask

  task automatic end_match();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    check_all_zero("to_idle");
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero(tag);
    step();
    check({tag, "_stay_idle"}, bus.disp_sel, DISP_TITLE);
  endtask

  initial begin
    int c1, c2;
    bus.start_btn = 1'b0;
    bus.p1_done   = 1'b0;
    bus.p2_done   = 1'b0;
    bus.green_block_count_p1 = 2'd0;
    bus.green_block_count_p2 = 2'd0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");

    // Match A: timeout win for P1, draw by done pulses, then done+timeout together
    start_match();
    play_round(NEVER, NEVER, 1'b0, 2, 1);
    hold_phase(1'b1);
    play_round(2, 7, 1'b0, 1, 1);
    hold_phase(1'b0);
    play_round(30, 5, 1'b0, 0, 3);
    hold_phase(1'b1);
    check("matchA_over", 32'(m_over), 1);
    end_match();

    // Match B: P1 takes two rounds and ends the match early
    start_match();
    play_round(3, 4, 1'b0, 3, 0);
    hold_phase(1'b0);
    play_round(0, 0, 1'b0, 2, 0);
    hold_phase(1'b0);
    check("matchB_over", 32'(m_over), 1);
    end_match();

    // Reset mid-PLAY and mid-HOLD
    start_match();
    for (int i = 0; i < 4; i++) step();
    pulse_reset("rst_play");
    start_match();
    play_round(1, 0, 1'b0, 0, 2);
    step();
    step();
    pulse_reset("rst_hold");

    // Random matches
    for (int m = 0; m < 4; m++) begin
      start_match();
      for (int r = 0; r < 3 && !m_over; r++) begin
        c1 = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 35));
        c2 = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 35));
        play_round(c1, c2, 1'b1, 0, 0);
        hold_phase(1'($urandom_range(0, 1)));
      end
      check("rand_over", 32'(m_over), 1);
      end_match();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
